// File: rtl/sample_readout_pkg.sv
// Shared types and width helpers for the sample readout scheduler.
package sample_readout_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd3,
        CHECK  = 3'd4
    } state_e;

    // Header words carry a marker in the MSB so they can never alias a channel index.
    function automatic int HEADER_MARKER(input int word_w);
        return word_w - 1;
    endfunction

    function automatic int CH_IDX_W(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int WORD_IDX_W(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/sample_readout_scheduler_rr_arbiter.sv
// Combinational round-robin select: first requester at or after the pointer, wrapping.
module rr_arbiter
    import sample_readout_pkg::*;
#(
    parameter int NUM_CH = 7
) (
    input  logic [NUM_CH-1:0]           req_i,
    input  logic [CH_IDX_W(NUM_CH)-1:0] ptr_i,
    output logic [NUM_CH-1:0]           grant_o,
    output logic [CH_IDX_W(NUM_CH)-1:0] idx_o,
    output logic                        any_req_o
);

    localparam int IW = CH_IDX_W(NUM_CH);

    // Scan channels starting at the pointer; the first hit wins.
    always_comb begin
        int cand;
        cand      = 0;
        grant_o   = '0;
        idx_o     = '0;
        any_req_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(ptr_i) + i) % NUM_CH;
            if (!any_req_o && req_i[cand]) begin
                any_req_o     = 1'b1;
                idx_o         = IW'(cand);
                grant_o[cand] = 1'b1;
            end else begin
                any_req_o = any_req_o;
            end
        end
    end

endmodule

// File: rtl/sample_readout_scheduler.sv
// Round-robin frame readout: header word, then buffer words, streamed over valid/ready.
// Optional trailer checksum word when SAMPLE_READOUT_CHECKSUM_EN is defined.
module sample_readout_scheduler
    import sample_readout_pkg::*;
#(
    parameter int NUM_CH          = 7,
    parameter int WORDS_PER_FRAME = 10,
    parameter int WORD_W          = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [NUM_CH-1:0]                     ch_req,
    output logic [NUM_CH-1:0]                     ch_ack,
    output logic [CH_IDX_W(NUM_CH)-1:0]           rd_ch,
    output logic [WORD_IDX_W(WORDS_PER_FRAME)-1:0] rd_word,
    input  logic [WORD_W-1:0]                     rd_data,
    output logic [WORD_W-1:0]                     out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int CW   = CH_IDX_W(NUM_CH);
    localparam int WW   = WORD_IDX_W(WORDS_PER_FRAME);
    localparam int MARK = HEADER_MARKER(WORD_W);
    localparam logic [WW-1:0] LAST_IDX = WW'(WORDS_PER_FRAME - 1);
`ifdef SAMPLE_READOUT_CHECKSUM_EN
    localparam logic LAST_ON_DATA = 1'b0;
`else
    localparam logic LAST_ON_DATA = 1'b1;
`endif

    state_e              state_q, state_d;
    logic [CW-1:0]       rd_ch_q, rd_ch_d, ptr_q, ptr_d;
    logic [WW-1:0]       rd_word_q, rd_word_d, idx_q, idx_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d, ch_ack_q, ch_ack_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
    logic [WORD_W-1:0]   xor_q, xor_d;
`endif

    logic [NUM_CH-1:0]   arb_gnt_s;
    logic [CW-1:0]       arb_idx_s;
    logic                arb_any_s;
    logic                hs_s;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i    (ch_req),
        .ptr_i    (ptr_q),
        .grant_o  (arb_gnt_s),
        .idx_o    (arb_idx_s),
        .any_req_o(arb_any_s)
    );

    assign hs_s = out_valid_q & out_ready;

    // Next-state and output-register update; rd_word runs one word ahead of out_data.
    always_comb begin
        state_d     = state_q;
        rd_ch_d     = rd_ch_q;
        rd_word_d   = rd_word_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        ch_ack_d    = '0;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable && arb_any_s) begin
                    state_d               = HEADER;
                    rd_ch_d               = arb_idx_s;
                    gnt_d                 = arb_gnt_s;
                    rd_word_d             = '0;
                    out_data_d            = '0;
                    out_data_d[MARK]      = 1'b1;
                    out_data_d[CW-1:0]    = arb_idx_s;
                    out_valid_d           = 1'b1;
                    out_last_d            = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            HEADER: begin
                if (hs_s) begin
                    state_d    = DATA;
                    out_data_d = rd_data;
                    idx_d      = '0;
                    rd_word_d  = (LAST_IDX != '0) ? WW'(1) : '0;
                    out_last_d = LAST_ON_DATA && (LAST_IDX == '0);
`ifdef SAMPLE_READOUT_CHECKSUM_EN
                    xor_d      = rd_data;
`endif
                end else begin
                    state_d = HEADER;
                end
            end
            DATA: begin
                if (hs_s && (idx_q == LAST_IDX)) begin
`ifdef SAMPLE_READOUT_CHECKSUM_EN
                    state_d     = CHECK;
                    out_data_d  = xor_q;
                    out_last_d  = 1'b1;
`else
                    state_d     = DONE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    ch_ack_d    = gnt_q;
`endif
                end else if (hs_s) begin
                    out_data_d = rd_data;
                    idx_d      = idx_q + WW'(1);
                    rd_word_d  = (rd_word_q == LAST_IDX) ? rd_word_q : rd_word_q + WW'(1);
                    out_last_d = LAST_ON_DATA && (idx_d == LAST_IDX);
`ifdef SAMPLE_READOUT_CHECKSUM_EN
                    xor_d      = xor_q ^ rd_data;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (hs_s) begin
                    state_d     = DONE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    ch_ack_d    = gnt_q;
                end else begin
                    state_d = CHECK;
                end
            end
            DONE: begin
                state_d   = IDLE;
                ptr_d     = (rd_ch_q == CW'(NUM_CH - 1)) ? '0 : rd_ch_q + CW'(1);
                rd_word_d = '0;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without acknowledging it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ch_q     <= '0;
            rd_word_q   <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ch_ack_q    <= '0;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ch_q     <= rd_ch_d;
            rd_word_q   <= rd_word_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ch_ack_q    <= ch_ack_d;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign rd_ch     = rd_ch_q;
    assign rd_word   = rd_word_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign ch_ack    = ch_ack_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sample_readout_scheduler.sv
// Scoreboard bench for sample_readout_scheduler: expected words/acks queued by stimulus, checked by a monitor.
module tb_sample_readout_scheduler;

    localparam int NUM_CH = 7;
    localparam int WPF    = 10;
    localparam int WORD_W = 8;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
    localparam int FRAME_WORDS = WPF + 2;
    localparam bit CKSUM       = 1'b1;
`else
    localparam int FRAME_WORDS = WPF + 1;
    localparam bit CKSUM       = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, enable, out_ready, out_valid, out_last, busy;
    logic [NUM_CH-1:0] ch_req, ch_ack;
    logic [2:0]        rd_ch;
    logic [3:0]        rd_word;
    logic [7:0]        rd_data, out_data;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t              exp_q[$];
    logic [NUM_CH-1:0] ack_q[$];
    int errors = 0, checks = 0, hs_count = 0, ack_count = 0;

    sample_readout_scheduler #(.NUM_CH(NUM_CH), .WORDS_PER_FRAME(WPF), .WORD_W(WORD_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_req(ch_req), .ch_ack(ch_ack),
        .rd_ch(rd_ch), .rd_word(rd_word), .rd_data(rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Channel 0 holds 01..0A, so its XOR trailer is 0B.
    function automatic logic [7:0] buf_word(input int ch, input int w);
        return 8'(ch * 16 + w + 1);
    endfunction

    assign rd_data = buf_word(int'(rd_ch), int'(rd_word));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic expect_frame(input int ch);
        logic [7:0] x;
        x = 8'h00;
        push_word(8'h80 | 8'(ch), 1'b0);
        for (int w = 0; w < WPF; w++) begin
            x = x ^ buf_word(ch, w);
            push_word(buf_word(ch, w), (w == WPF - 1) && !CKSUM);
        end
        if (CKSUM) push_word(x, 1'b1);
        ack_q.push_back(NUM_CH'(1) << ch);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        check("hs_wait", hs_count >= target, 1);
    endtask

    task automatic wait_ack(input int target);
        int n;
        n = 0;
        while (ack_count < target && n < 800) begin
            @(negedge clk); #1;
            n++;
        end
        check("ack_wait", ack_count >= target, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: pops expected words on handshakes and expected acks on ack pulses.
    initial begin
        logic              stall_prev;
        logic [7:0]        held_data;
        logic              held_last;
        logic [3:0]        held_word;
        logic [2:0]        held_ch;
        exp_t              e;
        logic [NUM_CH-1:0] a;
        stall_prev = 1'b0;
        held_data = '0; held_last = 1'b0; held_word = '0; held_ch = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_data", out_data, held_data);
                    check("stall_last", out_last, held_last);
                    check("stall_rd_word", rd_word, held_word);
                    check("stall_rd_ch", rd_ch, held_ch);
                end
                if (out_valid && out_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: got %02h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_last", out_last, e.last);
                    end
                end
                if (ch_ack != '0) begin
                    ack_count++;
                    if (ack_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack: got %b expected none", ch_ack);
                    end else begin
                        a = ack_q.pop_front();
                        check("ch_ack", ch_ack, a);
                    end
                end
                if (busy) check("rd_word_range", rd_word <= 4'(WPF - 1), 1);
                stall_prev = out_valid && !out_ready;
                held_data = out_data; held_last = out_last; held_word = rd_word; held_ch = rd_ch;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset = 1'b1; enable = 1'b0; ch_req = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ch_ack", ch_ack, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rd_ch", rd_ch, 0);
        check("rst_rd_word", rd_word, 0);
        reset = 1'b0;

        // Single channel-2 frame, header one cycle after the grant.
        expect_frame(2);
        ch_req = 7'b0000100; enable = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        check("grant_latency_valid", out_valid, 1);
        check("grant_rd_ch", rd_ch, 2);
        wait_ack(ack_count + 1);
        ch_req = '0;
        @(negedge clk); #1;
        check("ack_pulse_width", ch_ack, 0);

        // All channels requesting: round-robin 0..6 then 0.
        do_reset();
        for (int c = 0; c < NUM_CH; c++) expect_frame(c);
        expect_frame(0);
        ch_req = 7'b1111111;
        wait_ack(ack_count + 8);
        ch_req = '0;

        // Toggling backpressure; request dropped mid-frame is ignored.
        do_reset();
        expect_frame(1);
        base = hs_count;
        ch_req = 7'b0000010;
        begin
            int tgt;
            tgt = ack_count + 1;
            for (int i = 0; i < 400 && ack_count < tgt; i++) begin
                @(posedge clk); #1;
                out_ready = ~out_ready;
                if (busy) ch_req = '0;
            end
        end
        out_ready = 1'b1;
        ch_req = '0;
        check("toggle_handshakes", hs_count - base, FRAME_WORDS);

        // Reset after data word 4 of a channel-5 frame.
        do_reset();
        push_word(8'h85, 1'b0);
        for (int w = 0; w < 5; w++) push_word(buf_word(5, w), 1'b0);
        base = hs_count;
        ch_req = 7'b0100000;
        wait_hs(base + 6);
        reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_last", out_last, 0);
        check("abort_ch_ack", ch_ack, 0);
        check("abort_busy", busy, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ch_req = 7'b0100001;
        expect_frame(0);
        wait_ack(ack_count + 1);
        ch_req = '0;

        // Enable dropped after a channel-3 header; pointer wraps to channel 0.
        do_reset();
        expect_frame(2);
        ch_req = 7'b0000100;
        wait_ack(ack_count + 1);
        ch_req = 7'b0001001;
        expect_frame(3);
        base = hs_count;
        wait_hs(base + 1);
        enable = 1'b0;
        wait_ack(ack_count + 1);
        base = hs_count;
        repeat (20) @(negedge clk);
        #1;
        check("disabled_no_grant_valid", out_valid, 0);
        check("disabled_no_grant_busy", busy, 0);
        check("disabled_no_handshake", hs_count - base, 0);
        expect_frame(0);
        enable = 1'b1;
        wait_ack(ack_count + 1);
        ch_req = '0;

        repeat (5) @(negedge clk);
        #1;
        check("final_words_drained", exp_q.size(), 0);
        check("final_acks_drained", ack_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_readout_scheduler.md
Name: sample_readout_scheduler

Overview:
- Round-robin readout controller for the per-channel sample buffers: channels raise a frame-ready request, the scheduler grants one at a time, walks the granted buffer word by word through an external read mux, and streams header + data words out over a valid/ready interface.
- Sits between the channel capture buffers (read via rd_ch/rd_word/rd_data) and the output pins/serializer.

Parameters:
- NUM_CH, 7, number of sample channels (2..2**(WORD_W-1)).
- WORDS_PER_FRAME, 10, data words per channel frame.
- WORD_W, 8, width of a buffer word and of out_data.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- enable  in  1  permits new grants; an in-flight frame always completes.
- ch_req  in  NUM_CH  per-channel frame-ready (level).
- ch_ack  out  NUM_CH  one-hot, 1-cycle pulse when a channel's frame is fully sent.
- rd_ch  out  clog2(NUM_CH)  channel index driven to the buffer read mux.
- rd_word  out  clog2(WORDS_PER_FRAME)  word index driven to the buffer read mux.
- rd_data  in  WORD_W  combinational buffer word selected by rd_ch/rd_word.
- out_data  out  WORD_W  output word (registered).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_last  out  1  marks final word of a frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state IDLE, out_valid/out_last/busy/ch_ack = 0, out_data = 0, rd_ch = 0, rd_word = 0, RR pointer = 0 (channel 0 highest priority).
- States: IDLE, HEADER, DATA, DONE.
- IDLE: if enable & |ch_req, grant the first requesting channel at or after the RR pointer (wrapping); latch rd_ch; rd_word = 0; go HEADER. Grant to header out_valid = 1 cycle.
- HEADER: out_data = {1'b1, channel index zero-extended to WORD_W-1}, out_valid = 1, out_last = 0. On handshake go DATA and register rd_data (word 0) as the next out_data.
- DATA: out_data = registered rd_data for the current rd_word, MSB unrestricted. On each handshake rd_word increments; the next word is loaded in the same edge (no bubble under continuous out_ready). out_last = 1 on word WORDS_PER_FRAME-1. Handshake on the last word -> DONE.
- DONE (1 cycle): ch_ack[rd_ch] = 1, out_valid = 0, RR pointer = rd_ch+1 mod NUM_CH, rd_word = 0, go IDLE. Back-to-back frame: next header valid no earlier than 2 cycles after the last data handshake.
- Backpressure: while out_valid & !out_ready, out_data, out_last, rd_ch and rd_word are held stable.
- ch_req for the granted channel dropping mid-frame is ignored; the frame completes and is acked.
- enable low mid-frame: the frame completes; no new grant until enable is high.
- Reset mid-frame: immediate abort, no ch_ack, no out_last; output returns to the reset values.
- rd_word never exceeds WORDS_PER_FRAME-1. rd_ch never points to an ungranted channel while busy.

Optional Feature:
- Macro: SAMPLE_READOUT_CHECKSUM_EN.
- Defined: a CHECK state follows DATA and emits one trailer word = XOR of all data words in the frame. out_last moves from the last data word to the trailer. The frame is WORDS_PER_FRAME+2 words.
- Undefined: no trailer, no XOR register. The frame is WORDS_PER_FRAME+1 words.

Decomposition:
- Package sample_readout_pkg: state enum (IDLE, HEADER, DATA, DONE, CHECK), HEADER_MARKER bit position constant, CH_IDX_W and WORD_IDX_W width functions.
- Sub-module rr_arbiter: combinational NUM_CH-way round-robin select from a pointer. Outputs are the one-hot grant, index and any_req.

Test Plan:
- Reset, ch_req=7'b0000100, enable=1, out_ready=1 -> header 8'h82 one cycle after the grant, then 10 data words matching the buffer for rd_ch=2, out_last on word 10, ch_ack=7'b0000100 for 1 cycle.
- ch_req=7'b1111111 held -> frames granted in order 0,1,2,3,4,5,6,0. Headers are 8'h80, 8'h81, … 8'h86, 8'h80.
- out_ready toggling 1010… during DATA -> out_data/rd_word stable while stalled, no dropped or duplicated words, 11 handshakes total.
- Reset asserted after word 4 of a channel-5 frame -> out_valid=0 immediately, no ch_ack, next grant restarts from channel 0.
- enable dropped after the header of a channel-3 frame with ch_req=7'b0001001 -> channel 3 completes and is acked, no further header until enable=1, then channel 0 is granted (pointer=4 wraps).
- SAMPLE_READOUT_CHECKSUM_EN defined, data words 8'h01..8'h0A -> trailer 8'h0B with out_last, 12 words per frame.
